// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   MD_WIDTH   operand/result width
//   MD_CNT_W   iteration counter width
//   MD_CYCLES  steps per operation (equals the operand width)
//   md_state_t FSM state encoding
package multdiv_unit_pkg;

  localparam int MD_WIDTH  = 32;
  localparam int MD_CNT_W  = 6;
  localparam int MD_CYCLES = MD_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/multdiv_div_step.sv
// One non-restoring divide iteration on magnitudes, purely combinational.
//   rem       in   WIDTH+2  signed partial remainder
//   quo       in   WIDTH    dividend bits still to shift in / quotient bits built so far
//   divisor   in   WIDTH+1  unsigned divisor magnitude
//   rem_next  out  WIDTH+2  partial remainder after the add/subtract
//   quo_next  out  WIDTH    quo shifted left with the new quotient bit in the LSB
module multdiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH+1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dvsr_ext;

  always_comb begin
    // The remainder stays within [-d, d), so its top bit is only a sign copy
    // and can be dropped by the shift.
    shifted  = {rem[WIDTH:0], quo[WIDTH-1]};
    dvsr_ext = {1'b0, divisor};
    if (rem[WIDTH+1]) begin
      rem_next = shifted + dvsr_ext;
    end else begin
      rem_next = shifted - dvsr_ext;
    end
    // Quotient digit is 1 whenever the new remainder is non-negative.
    quo_next = {quo[WIDTH-2:0], ~rem_next[WIDTH+1]};
  end

endmodule

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (non-restoring) unit.
//   clock           in   1      rising-edge clock
//   reset           in   1      asynchronous active-low reset
//   data_operandA   in   WIDTH  multiplicand / dividend, sampled on a start edge
//   data_operandB   in   WIDTH  multiplier / divisor, sampled on a start edge
//   ctrl_MULT       in   1      start multiply (wins over ctrl_DIV)
//   ctrl_DIV        in   1      start divide
//   data_result     out  WIDTH  low product bits or quotient, held until next completion
//   data_exception  out  1      multiply overflow or divide error for data_result
//   data_resultRDY  out  1      one-cycle completion pulse
//   state_dbg       out  2      current FSM state
//
// Handshake: a start pulse is accepted on every rising edge it is seen,
// in any state, and restarts the unit; data_resultRDY is high for exactly
// the one cycle after the final step, and data_result/data_exception are
// valid from that cycle until the next completion.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output md_state_t        state_dbg
);

  md_state_t        state;
  logic [CNT_W-1:0] count;

  // Booth datapath: accumulator is one bit wider so that subtracting the
  // most-negative multiplicand cannot overflow.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mq;
  logic             mq_m1;
  logic [WIDTH-1:0] mcand;

  // Divide datapath
  logic [WIDTH+1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   dvsr;
  logic             q_neg;
  logic             b_zero;
  logic             div_ovf;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] mq_next;
  logic             mq_m1_next;
  logic [WIDTH:0]   prod_hi;
  logic             mul_ovf;

  logic [WIDTH+1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] div_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             last_step;

  assign state_dbg = state;
  assign last_step = (count == CNT_W'(MD_CYCLES - 1));

  // Magnitudes fit in WIDTH unsigned bits, including |-2^(WIDTH-1)|.
  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  always_comb begin
    m_ext     = {mcand[WIDTH-1], mcand};
    booth_sum = acc;
    case ({mq[0], mq_m1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
    // Arithmetic shift right of {acc, mq, mq_m1}.
    acc_next   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mq_next    = {booth_sum[0], mq[WIDTH-1:1]};
    mq_m1_next = mq[0];
    // Product bits [2W-1:W-1] must all match for the low half to be exact.
    prod_hi    = {acc_next[WIDTH-1:0], mq_next[WIDTH-1]};
    mul_ovf    = ~((&prod_hi) | ~(|prod_hi));
  end

  multdiv_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvsr),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign div_q = q_neg ? -quo_next : quo_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      acc            <= '0;
      mq             <= '0;
      mq_m1          <= 1'b0;
      mcand          <= '0;
      rem            <= '0;
      quo            <= '0;
      dvsr           <= '0;
      q_neg          <= 1'b0;
      b_zero         <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        state <= MULT;
        count <= '0;
        acc   <= '0;
        mq    <= data_operandB;
        mq_m1 <= 1'b0;
        mcand <= data_operandA;
      end else if (ctrl_DIV) begin
        state   <= DIV;
        count   <= '0;
        rem     <= '0;
        quo     <= a_mag;
        dvsr    <= {1'b0, b_mag};
        q_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        b_zero  <= (data_operandB == '0);
        div_ovf <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (data_operandB == '1);
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          MULT: begin
            acc   <= acc_next;
            mq    <= mq_next;
            mq_m1 <= mq_m1_next;
            count <= count + 1'b1;
            if (last_step) begin
              state          <= DONE;
              data_result    <= mq_next;
              data_exception <= mul_ovf;
              data_resultRDY <= 1'b1;
            end
          end
          DIV: begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + 1'b1;
            if (last_step) begin
              state          <= DONE;
              data_resultRDY <= 1'b1;
              if (b_zero) begin
                data_result    <= '0;
                data_exception <= 1'b1;
              end else begin
                // -2^(W-1) / -1 already yields the wrapped 2^(W-1) pattern.
                data_result    <= div_q;
                data_exception <= div_ovf;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
module tb_multdiv_unit;
  import multdiv_unit_pkg::*;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic         ctrl_MULT;
  logic         ctrl_DIV;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  md_state_t    state_dbg;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_exc_q[$];
  int           exp_cyc_q[$];
  int           checks = 0;
  int           errors = 0;
  int           rdy_count = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (reset && data_resultRDY) begin
      rdy_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: RDY seen at cycle %0d, expected none", cyc);
      end else begin
        logic [W-1:0] r;
        logic         e;
        int           c;
        r = exp_q.pop_front();
        e = exp_exc_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("result", data_result, r);
        check("exception", W'(data_exception), W'(e));
        check("rdy_cycle", W'(cyc), W'(c));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives a one-cycle start pulse; when want_rdy is set the completion is
  // expected exactly 32 edges after the start edge.
  task automatic start_op(input bit mult, input bit div,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input bit exc, input bit want_rdy);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mult;
    ctrl_DIV      = div;
    if (want_rdy) begin
      exp_q.push_back(res);
      exp_exc_q.push_back(exc);
      exp_cyc_q.push_back(cyc + 33);
    end
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
      exp_exc_q.delete();
      exp_cyc_q.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  int rdy0;

  initial begin
    reset         = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_result", data_result, '0);
    check("reset_exc", W'(data_exception), '0);
    check("reset_rdy", W'(data_resultRDY), '0);
    check("reset_state", W'(state_dbg), W'(IDLE));
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Multiply vectors
    start_op(1, 0, 32'd6, -32'sd7, 32'hFFFFFFD6, 0, 1);
    wait_done();
    check("hold_result", data_result, 32'hFFFFFFD6);
    start_op(1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1, 1);
    wait_done();
    start_op(1, 0, 32'h80000000, 32'd1, 32'h80000000, 0, 1);
    wait_done();
    start_op(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 1);
    wait_done();
    start_op(1, 0, 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1, 1);
    wait_done();

    // Divide vectors
    start_op(0, 1, -32'sd17, 32'd5, 32'hFFFFFFFD, 0, 1);
    wait_done();
    start_op(0, 1, 32'd100, 32'd0, 32'h00000000, 1, 1);
    wait_done();
    start_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1);
    wait_done();
    start_op(0, 1, 32'd7, -32'sd2, 32'hFFFFFFFD, 0, 1);
    wait_done();
    start_op(0, 1, 32'h80000000, 32'd2, 32'hC0000000, 0, 1);
    wait_done();

    // Simultaneous starts: multiply wins, single RDY
    rdy0 = rdy_count;
    start_op(1, 1, 32'd9, 32'd3, 32'd27, 0, 1);
    wait_done();
    check("both_rdy_pulses", W'(rdy_count - rdy0), W'(1));

    // Abort a multiply with a divide issued 10 cycles later
    rdy0 = rdy_count;
    start_op(1, 0, 32'd5, 32'd5, 32'd25, 0, 0);
    repeat (8) @(negedge clock);
    start_op(0, 1, 32'd20, 32'd4, 32'd5, 0, 1);
    wait_done();
    check("abort_rdy_pulses", W'(rdy_count - rdy0), W'(1));

    // Asynchronous reset in the middle of a divide
    start_op(0, 1, 32'd1000, 32'd7, 32'd142, 0, 0);
    repeat (13) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midreset_result", data_result, '0);
    check("midreset_exc", W'(data_exception), '0);
    check("midreset_rdy", W'(data_resultRDY), '0);
    check("midreset_state", W'(state_dbg), W'(IDLE));
    @(negedge clock);
    reset = 1'b1;
    rdy0 = rdy_count;
    repeat (40) @(negedge clock);
    check("post_reset_no_rdy", W'(rdy_count - rdy0), '0);
    start_op(1, 0, 32'd2, 32'd3, 32'd6, 0, 1);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
